vga_pixel_compositor: RTL and testbench

Downstream stage of the VGA shape detectors (hexagon bumpers, ball, etc.). Merges their registered per-pixel hit flags into one 12-bit RGB pixel using a fixed priority and realigns hsync/vsync/video_on with the detectors' pipeline latency. Runs a per-shape collision-flash timer that blinks a bumper's colour for a set number of frames after the game logic signals a hit. Its outputs drive the VGA DAC pins directly.

---
 rtl/vga_pixel_compositor.sv | 131 +++++++++++++
 tb/tb_vga_pixel_compositor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_compositor.sv
// Merges registered shape/ball hit flags into one RGB pixel. Realigns the syncs with the
// detector latency and runs a per-shape frame-counted collision flash.
module vga_pixel_compositor #(
    parameter int unsigned N_SHAPES     = 4,
    parameter int unsigned DET_LAT      = 3,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned COLOR_W      = 12
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          video_on_in,
    input  logic [N_SHAPES-1:0]           shape_hit,
    input  logic                          ball_hit,
    input  logic [N_SHAPES*COLOR_W-1:0]   shape_color,
    input  logic [COLOR_W-1:0]            ball_color,
    input  logic [COLOR_W-1:0]            bg_color,
    input  logic [N_SHAPES-1:0]           flash_req,
    output logic [COLOR_W-1:0]            rgb,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic [N_SHAPES-1:0]           flash_active
);

    localparam logic [7:0] FlashLoad = 8'(FLASH_FRAMES);

    // Sync/video_on delay lines; index DET_LAT-1 is the oldest sample.
    logic [DET_LAT-1:0] hs_sr_q, hs_sr_d;
    logic [DET_LAT-1:0] vs_sr_q, vs_sr_d;
    logic [DET_LAT-1:0] vo_sr_q, vo_sr_d;
    logic               vo_d;

    logic               vs_prev_q;
    logic               frame_tick;

    logic [7:0]         flash_cnt_q [N_SHAPES];
    logic [7:0]         flash_cnt_d [N_SHAPES];

    logic [COLOR_W-1:0] shape_col [N_SHAPES];
    logic [COLOR_W-1:0] rgb_d;

    always_comb begin
        hs_sr_d    = hs_sr_q;
        vs_sr_d    = vs_sr_q;
        vo_sr_d    = vo_sr_q;
        hs_sr_d[0] = hsync_in;
        vs_sr_d[0] = vsync_in;
        vo_sr_d[0] = video_on_in;
        for (int i = 1; i < int'(DET_LAT); i++) begin
            hs_sr_d[i] = hs_sr_q[i-1];
            vs_sr_d[i] = vs_sr_q[i-1];
            vo_sr_d[i] = vo_sr_q[i-1];
        end
    end

    assign vo_d       = vo_sr_q[DET_LAT-1];
    assign frame_tick = vs_prev_q & ~vsync_in;

    always_comb begin
        for (int i = 0; i < int'(N_SHAPES); i++) begin
            flash_cnt_d[i] = flash_cnt_q[i];
            if (flash_req[i]) begin
                flash_cnt_d[i] = FlashLoad;
            end else if (frame_tick && (flash_cnt_q[i] != 8'd0)) begin
                flash_cnt_d[i] = flash_cnt_q[i] - 8'd1;
            end
        end
    end

    // Odd counts show the inverted colour, giving a blink that ends on the normal colour.
    always_comb begin
        for (int i = 0; i < int'(N_SHAPES); i++) begin
            shape_col[i] = shape_color[i*COLOR_W +: COLOR_W];
            if (flash_cnt_q[i][0]) begin
                shape_col[i] = ~shape_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Descending scan so the lowest hit index is the last writer and wins.
    always_comb begin
        rgb_d = '0;
        if (vo_d) begin
            if (ball_hit) begin
                rgb_d = ball_color;
            end else begin
                rgb_d = bg_color;
                for (int i = int'(N_SHAPES) - 1; i >= 0; i--) begin
                    if (shape_hit[i]) begin
                        rgb_d = shape_col[i];
                    end
                end
            end
        end
    end

    always_comb begin
        flash_active = '0;
        for (int i = 0; i < int'(N_SHAPES); i++) begin
            flash_active[i] = (flash_cnt_q[i] != 8'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_sr_q   <= '1;
            vs_sr_q   <= '1;
            vo_sr_q   <= '0;
            vs_prev_q <= 1'b1;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            rgb       <= '0;
            for (int i = 0; i < int'(N_SHAPES); i++) begin
                flash_cnt_q[i] <= 8'd0;
            end
        end else begin
            hs_sr_q   <= hs_sr_d;
            vs_sr_q   <= vs_sr_d;
            vo_sr_q   <= vo_sr_d;
            vs_prev_q <= vsync_in;
            hsync_out <= hs_sr_q[DET_LAT-1];
            vsync_out <= vs_sr_q[DET_LAT-1];
            rgb       <= rgb_d;
            for (int i = 0; i < int'(N_SHAPES); i++) begin
                flash_cnt_q[i] <= flash_cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_compositor.sv
// Scoreboard bench for vga_pixel_compositor: stimulus pushes expected outputs computed from
// input history; a monitor pops one entry per clock and compares.
module tb_vga_pixel_compositor;

    localparam int NS = 4;
    localparam int DL = 3;
    localparam int FF = 8;
    localparam int CW = 12;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             hsync_in = 1'b1;
    logic             vsync_in = 1'b1;
    logic             video_on_in = 1'b0;
    logic [NS-1:0]    shape_hit = '0;
    logic             ball_hit = 1'b0;
    logic [NS*CW-1:0] shape_color = '0;
    logic [CW-1:0]    ball_color = '0;
    logic [CW-1:0]    bg_color = '0;
    logic [NS-1:0]    flash_req = '0;
    logic [CW-1:0]    rgb;
    logic             hsync_out;
    logic             vsync_out;
    logic [NS-1:0]    flash_active;

    vga_pixel_compositor #(
        .N_SHAPES    (NS),
        .DET_LAT     (DL),
        .FLASH_FRAMES(FF),
        .COLOR_W     (CW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .video_on_in (video_on_in),
        .shape_hit   (shape_hit),
        .ball_hit    (ball_hit),
        .shape_color (shape_color),
        .ball_color  (ball_color),
        .bg_color    (bg_color),
        .flash_req   (flash_req),
        .rgb         (rgb),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .flash_active(flash_active)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [CW-1:0] rgb;
        logic          hs;
        logic          vs;
        logic [NS-1:0] fa;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Input history indexed by clock edge number, plus the frame counters of the model.
    logic rst_h[$];
    logic hs_h[$];
    logic vs_h[$];
    logic vo_h[$];
    int   cnt_m[NS];

    function automatic logic reset_in(input int lo, input int hi);
        for (int j = lo; j <= hi; j++) begin
            if (j < 0) return 1'b1;
            if (rst_h[j]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Computes what the DUT must show after the coming edge, then waits to the next negedge.
    task automatic step();
        exp_t          e;
        int            k;
        logic          vo_d;
        logic          prev_vs;
        logic          tick;
        logic [CW-1:0] base;
        rst_h.push_back(RST);
        hs_h.push_back(hsync_in);
        vs_h.push_back(vsync_in);
        vo_h.push_back(video_on_in);
        k = rst_h.size() - 1;

        if (reset_in(k - DL, k)) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            e.hs = hs_h[k-DL];
            e.vs = vs_h[k-DL];
        end
        if (reset_in(k - DL, k - 1)) vo_d = 1'b0;
        else                         vo_d = vo_h[k-DL];

        if (RST || !vo_d) begin
            e.rgb = '0;
        end else if (ball_hit) begin
            e.rgb = ball_color;
        end else begin
            e.rgb = bg_color;
            for (int i = 0; i < NS; i++) begin
                if (shape_hit[i]) begin
                    base  = shape_color[i*CW +: CW];
                    e.rgb = (cnt_m[i] % 2 == 1) ? ~base : base;
                    break;
                end
            end
        end

        if (k == 0)           prev_vs = 1'b1;
        else if (rst_h[k-1])  prev_vs = 1'b1;
        else                  prev_vs = vs_h[k-1];
        tick = prev_vs && !vsync_in;

        for (int i = 0; i < NS; i++) begin
            if (RST)                          cnt_m[i] = 0;
            else if (flash_req[i])            cnt_m[i] = FF;
            else if (tick && cnt_m[i] > 0)    cnt_m[i] = cnt_m[i] - 1;
            e.fa[i] = (cnt_m[i] != 0);
        end
        sb.push_back(e);
        @(negedge CLK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rgb", 32'(rgb), 32'(e.rgb));
                check("hsync_out", 32'(hsync_out), 32'(e.hs));
                check("vsync_out", 32'(vsync_out), 32'(e.vs));
                check("flash_active", 32'(flash_active), 32'(e.fa));
            end
        end
    end

    // One frame boundary followed by a few visible pixels of shape 0.
    task automatic frame();
        vsync_in  = 1'b0;
        shape_hit = '0;
        step();
        step();
        vsync_in    = 1'b1;
        video_on_in = 1'b1;
        shape_hit   = 4'b0001;
        repeat (DL + 2) step();
        shape_hit = '0;
        step();
    endtask

    initial begin : stim
        int guard;
        // Reset with hsync low and video on: outputs must hold reset values until refill.
        RST = 1'b1; hsync_in = 1'b0; video_on_in = 1'b1;
        shape_color = {12'h00F, 12'hF80, 12'h0AA, 12'h0F0};
        ball_color  = 12'hFFF;
        bg_color    = 12'h123;
        step();
        step();
        RST = 1'b0;
        repeat (6) step();
        hsync_in = 1'b1;
        repeat (4) step();

        // Latency: hsync low pulse and a shape 2 hit.
        hsync_in = 1'b0;
        step();
        hsync_in = 1'b1;
        repeat (4) step();
        shape_hit = 4'b0100;
        step();
        shape_hit = '0;
        step();

        // Priority: ball over shapes, lowest shape index over higher, then background.
        ball_hit = 1'b1; shape_hit = 4'b0110;
        step();
        ball_hit = 1'b0;
        step();
        shape_hit = '0;
        step();

        // Blanking: delayed video_on low forces black even with all hits.
        video_on_in = 1'b0;
        repeat (DL) step();
        shape_hit = 4'b1111;
        step();
        video_on_in = 1'b1;
        step();
        shape_hit = '0;
        repeat (DL) step();

        // Flash of shape 0 across its whole lifetime.
        flash_req = 4'b0001;
        step();
        flash_req = '0;
        repeat (FF + 1) frame();

        // Load wins over a coincident frame tick.
        vsync_in  = 1'b0;
        flash_req = 4'b0010;
        step();
        flash_req = '0;
        step();
        vsync_in = 1'b1;
        step();
        // Re-request at count 3 restarts the flash.
        guard = 0;
        while (cnt_m[1] != 3 && guard < 20) begin frame(); guard++; end
        flash_req = 4'b0010;
        step();
        flash_req = '0;
        step();
        // Reset at count 5 aborts it.
        guard = 0;
        while (cnt_m[1] != 5 && guard < 20) begin frame(); guard++; end
        RST = 1'b1;
        step();
        RST = 1'b0;
        repeat (DL + 2) step();

        // Randomised traffic, including mid-stream resets and frequent frame edges.
        for (int n = 0; n < 3000; n++) begin
            RST         = ($urandom_range(0, 299) == 0);
            hsync_in    = ($urandom_range(0, 9) != 0);
            vsync_in    = ($urandom_range(0, 11) != 0);
            video_on_in = ($urandom_range(0, 7) != 0);
            shape_hit   = NS'($urandom);
            ball_hit    = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < NS; i++) begin
                flash_req[i] = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 15) == 0) begin
                shape_color = {CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom)};
                ball_color  = CW'($urandom);
                bg_color    = CW'($urandom);
            end
            step();
        end

        RST = 1'b0; flash_req = '0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
